// File: rtl/pc_unidade_excecao_if.sv
// pc_unidade_excecao_if
//   Vector-table read bus between the PC/exception unit and memory.
//   Signals:
//     mem_read  - read strobe, high while a vector read is in flight
//     mem_addr  - byte address of the vector-table entry (WIDTH bits)
//     mem_data  - vector-table byte returned by memory
//   Modports:
//     master - PC/exception unit (drives mem_read/mem_addr, reads mem_data)
//     slave  - memory side
interface pc_unidade_excecao_if #(
  parameter int WIDTH = 32
);
  logic             mem_read;
  logic [WIDTH-1:0] mem_addr;
  logic [7:0]       mem_data;

  modport master (output mem_read, output mem_addr, input mem_data);
  modport slave  (input mem_read, input mem_addr, output mem_data);
endinterface

// File: rtl/pc_unidade_excecao.sv
// pc_unidade_excecao
//   Program counter / EPC holder for the multicycle MIPS datapath. Selects
//   the next PC, gates PC writes, and runs exception entry by reading the
//   handler address byte from a memory vector table.
//   Ports:
//     i_clk, i_reset       - clock, synchronous active-high reset
//     i_pc_source          - next-PC source select (0 ALU, 1 ALUOut,
//                            2 RegDesloc, 3 JR, 4 EPC, 5-7 ALU)
//     i_pc_write           - unconditional PC write enable
//     i_pc_write_cond      - conditional PC write enable
//     i_branch_taken       - qualifies i_pc_write_cond
//     i_alu, i_alu_out,
//     i_reg_desloc, i_jr   - candidate next-PC values
//     i_exc_req            - exception request pulse
//     i_exc_cause          - cause code, valid with i_exc_req
//     io_mem               - vector-table read bus (master modport)
//     o_pc, o_epc          - program counter and exception PC registers
//     o_exc_busy           - exception entry in progress (stall)
//   Optional feature macro: PC_ALIGN_CHECK_EN
//     When defined, an enabled PC write in IDLE whose target has bits
//     [1:0] != 0 is replaced by an exception entry with cause ALIGN_CAUSE.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   S_IDLE | normal operation, PC writes accepted
//   S_REQ  | vector read in flight, counter runs 0..MEM_LAT-1
//   S_LOAD | handler address byte loads into PC
module pc_unidade_excecao #(
  parameter int               WIDTH       = 32,
  parameter int               CAUSE_W     = 2,
  parameter int               VEC_BASE    = 253,
  parameter int               MEM_LAT     = 2,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               ALIGN_CAUSE = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [2:0]           i_pc_source,
  input  logic                 i_pc_write,
  input  logic                 i_pc_write_cond,
  input  logic                 i_branch_taken,
  input  logic [WIDTH-1:0]     i_alu,
  input  logic [WIDTH-1:0]     i_alu_out,
  input  logic [WIDTH-1:0]     i_reg_desloc,
  input  logic [WIDTH-1:0]     i_jr,
  input  logic                 i_exc_req,
  input  logic [CAUSE_W-1:0]   i_exc_cause,
  pc_unidade_excecao_if.master io_mem,
  output logic [WIDTH-1:0]     o_pc,
  output logic [WIDTH-1:0]     o_epc,
  output logic                 o_exc_busy
);

  localparam int               CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_LAT - 1);

  // Catch configurations where the alignment cause cannot be encoded or
  // the memory latency is meaningless.
  if ((ALIGN_CAUSE >= (1 << CAUSE_W)) || (MEM_LAT < 1)) begin : g_bad_param
    $error("pc_unidade_excecao: ALIGN_CAUSE must fit CAUSE_W and MEM_LAT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic [WIDTH-1:0] r_mem_addr;
  logic             r_exc_busy;

  logic [WIDTH-1:0]   w_target;
  logic               w_wr_en;
  logic               w_exc_start;
  logic [CAUSE_W-1:0] w_cause;

  always_comb begin
    w_target = i_alu;
    case (i_pc_source)
      3'd0:    w_target = i_alu;
      3'd1:    w_target = i_alu_out;
      3'd2:    w_target = i_reg_desloc;
      3'd3:    w_target = i_jr;
      3'd4:    w_target = r_epc;
      default: w_target = i_alu;
    endcase
  end

  assign w_wr_en = i_pc_write | (i_pc_write_cond & i_branch_taken);

  // External request always wins; a misaligned target only starts an entry
  // when no external request is present in the same cycle.
  always_comb begin
    w_exc_start = i_exc_req;
    w_cause     = i_exc_cause;
`ifdef PC_ALIGN_CHECK_EN
    if (!i_exc_req && w_wr_en && (w_target[1:0] != 2'b00)) begin
      w_exc_start = 1'b1;
      w_cause     = CAUSE_W'(ALIGN_CAUSE);
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pc       <= RESET_PC;
      r_epc      <= '0;
      r_mem_addr <= '0;
      r_exc_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_exc_start) begin
            r_state    <= S_REQ;
            r_cnt      <= '0;
            r_epc      <= r_pc - WIDTH'(4);
            // The latched cause lives on as the vector address.
            r_mem_addr <= WIDTH'(VEC_BASE) + WIDTH'(w_cause);
            r_exc_busy <= 1'b1;
          end else if (w_wr_en) begin
            r_pc <= w_target;
          end
        end
        S_REQ: begin
          if (r_cnt == CNT_MAX) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_LOAD: begin
          r_pc       <= WIDTH'(io_mem.mem_data);
          r_state    <= S_IDLE;
          r_exc_busy <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_exc_busy <= 1'b0;
        end
      endcase
    end
  end

  assign io_mem.mem_read = (r_state == S_REQ);
  assign io_mem.mem_addr = r_mem_addr;
  assign o_pc            = r_pc;
  assign o_epc           = r_epc;
  assign o_exc_busy      = r_exc_busy;

endmodule
